// File: rtl/vending_pkg.sv
// Shared encodings, coin values, item prices and customer FSM types used by
// the vending customer transactor and anything that talks to the machine.
package vending_pkg;

  // Machine service state as seen on serviceTypeOut
  localparam logic [1:0] SERVICE_OFF  = 2'd0;
  localparam logic [1:0] SERVICE_ON   = 2'd1;
  localparam logic [1:0] SERVICE_BUSY = 2'd2;

  // Item codes on itemTypeIn / itemTypeOut
  localparam logic [1:0] ITEM_NONE = 2'd0;
  localparam logic [1:0] ITEM_A    = 2'd1;
  localparam logic [1:0] ITEM_B    = 2'd2;
  localparam logic [1:0] ITEM_C    = 2'd3;

  // Coin denominations in NTD
  localparam logic [9:0] NTD_50 = 10'd50;
  localparam logic [9:0] NTD_10 = 10'd10;
  localparam logic [9:0] NTD_5  = 10'd5;
  localparam logic [9:0] NTD_1  = 10'd1;

  // Item prices in NTD
  localparam logic [9:0] COST_A = 10'd8;
  localparam logic [9:0] COST_B = 10'd15;
  localparam logic [9:0] COST_C = 10'd22;

  typedef enum logic [2:0] {
    CUST_PURCHASED = 3'd0,
    CUST_REFUNDED  = 3'd1,
    CUST_MISMATCH  = 3'd2,
    CUST_TIMEOUT   = 3'd3,
    CUST_REJECTED  = 3'd4
  } cust_status_t;

  typedef enum logic [2:0] {
    CS_IDLE  = 3'd0,
    CS_ISSUE = 3'd1,
    CS_WAIT  = 3'd2,
    CS_CHECK = 3'd3,
    CS_RESP  = 3'd4
  } cust_state_t;

  // Price of an item; ITEM_NONE is the only code that costs nothing
  function automatic logic [9:0] itemCost(input logic [1:0] item);
    case (item)
      ITEM_A:  itemCost = COST_A;
      ITEM_B:  itemCost = COST_B;
      ITEM_C:  itemCost = COST_C;
      default: itemCost = 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_value_calc.sv
// Turns a set of coin counts into an NTD value and an item code into its price.
// Pure combinational; 10 bits holds the largest change (7 of every coin = 462).
module vending_value_calc
  import vending_pkg::*;
(
  input  logic [2:0] i_n50,
  input  logic [2:0] i_n10,
  input  logic [2:0] i_n5,
  input  logic [2:0] i_n1,
  input  logic [1:0] i_item,
  output logic [9:0] o_value,
  output logic [9:0] o_cost
);

  // Weighted sum of coin counts plus the price lookup
  always_comb begin
    o_value = 10'(i_n50) * NTD_50 + 10'(i_n10) * NTD_10
            + 10'(i_n5) * NTD_5 + 10'(i_n1) * NTD_1;
    o_cost  = itemCost(i_item);
  end

endmodule

// File: rtl/vending_customer.sv
// Customer-side transactor for the vending machine: takes one purchase
// request, plays it into the machine, captures what comes back and reports
// whether the machine behaved (purchase, refund, mismatch, timeout, reject).
module vending_customer
  import vending_pkg::*;
#(
  parameter int TIMEOUT = 64
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_item,
  input  logic [1:0] req_ntd50,
  input  logic [1:0] req_ntd10,
  input  logic [1:0] req_ntd5,
  input  logic [1:0] req_ntd1,
  input  logic [1:0] vend_service,
  input  logic [1:0] vend_item,
  input  logic [2:0] vend_out50,
  input  logic [2:0] vend_out10,
  input  logic [2:0] vend_out5,
  input  logic [2:0] vend_out1,
  output logic [1:0] coin_in50,
  output logic [1:0] coin_in10,
  output logic [1:0] coin_in5,
  output logic [1:0] coin_in1,
  output logic [1:0] item_req,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_status,
  output logic [1:0] rsp_item,
  output logic [7:0] rsp_paid,
  output logic [9:0] rsp_change
);

  localparam int CW = $clog2(TIMEOUT + 1);

  cust_state_t  r_state, w_stateNext;
  logic [CW-1:0] r_count, w_countNext;
  logic         w_accept, w_timeout, w_capture, w_balanced;
  logic [1:0]   r_reqItem, r_capItem;
  logic [2:0]   r_cap50, r_cap10, r_cap5, r_cap1;
  logic [9:0]   r_paid, w_paidValue, w_reqCost, w_change, w_capCost;
  logic [1:0]   r_coin50, r_coin10, r_coin5, r_coin1, r_itemReq;
  logic         r_rspValid;
  cust_status_t r_rspStatus;
  logic [1:0]   r_rspItem;
  logic [7:0]   r_rspPaid;
  logic [9:0]   r_rspChange;

  vending_value_calc u_paidCalc (
    .i_n50   ({1'b0, req_ntd50}),
    .i_n10   ({1'b0, req_ntd10}),
    .i_n5    ({1'b0, req_ntd5}),
    .i_n1    ({1'b0, req_ntd1}),
    .i_item  (req_item),
    .o_value (w_paidValue),
    .o_cost  (w_reqCost)
  );

  vending_value_calc u_changeCalc (
    .i_n50   (r_cap50),
    .i_n10   (r_cap10),
    .i_n5    (r_cap5),
    .i_n1    (r_cap1),
    .i_item  (r_capItem),
    .o_value (w_change),
    .o_cost  (w_capCost)
  );

  // Money balances when change plus the price of what came out equals what
  // went in; with ITEM_NONE (free) that is exactly a full refund.
  assign w_balanced = ((w_change + w_capCost) == r_paid);

  assign req_ready  = (r_state == CS_IDLE);
  assign coin_in50  = r_coin50;
  assign coin_in10  = r_coin10;
  assign coin_in5   = r_coin5;
  assign coin_in1   = r_coin1;
  assign item_req   = r_itemReq;
  assign rsp_valid  = r_rspValid;
  assign rsp_status = r_rspStatus;
  assign rsp_item   = r_rspItem;
  assign rsp_paid   = r_rspPaid;
  assign rsp_change = r_rspChange;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CS_IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state decode; capture of the OFF cycle beats a same-cycle timeout.
  // A zero-cost request can only be ITEM_NONE, so it is rejected at once.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_capture   = 1'b0;
    w_countNext = r_count + CW'(1);
    case (r_state)
      CS_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_stateNext = (w_reqCost == 10'd0) ? CS_RESP : CS_ISSUE;
        end
      end
      CS_ISSUE: begin
        if (w_countNext == CW'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_stateNext = CS_RESP;
        end else if (vend_service == SERVICE_BUSY) begin
          w_stateNext = CS_WAIT;
        end
      end
      CS_WAIT: begin
        if (vend_service == SERVICE_OFF) begin
          w_capture   = 1'b1;
          w_stateNext = CS_CHECK;
        end else if (w_countNext == CW'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_stateNext = CS_RESP;
        end
      end
      CS_CHECK: w_stateNext = CS_RESP;
      CS_RESP:  if (rsp_ready) w_stateNext = CS_IDLE;
      default:  w_stateNext = CS_IDLE;
    endcase
  end

  // Datapath: latch the request, drive the machine, capture its answer and
  // build the response, which stays frozen until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_reqItem   <= ITEM_NONE;
      r_paid      <= 10'd0;
      r_capItem   <= ITEM_NONE;
      r_cap50     <= 3'd0;
      r_cap10     <= 3'd0;
      r_cap5      <= 3'd0;
      r_cap1      <= 3'd0;
      r_coin50    <= 2'd0;
      r_coin10    <= 2'd0;
      r_coin5     <= 2'd0;
      r_coin1     <= 2'd0;
      r_itemReq   <= ITEM_NONE;
      r_rspValid  <= 1'b0;
      r_rspStatus <= CUST_PURCHASED;
      r_rspItem   <= ITEM_NONE;
      r_rspPaid   <= 8'd0;
      r_rspChange <= 10'd0;
    end else begin
      case (r_state)
        CS_IDLE: begin
          if (w_accept) begin
            r_reqItem <= req_item;
            r_paid    <= w_paidValue;
            r_count   <= '0;
            if (w_stateNext == CS_ISSUE) begin
              r_coin50  <= req_ntd50;
              r_coin10  <= req_ntd10;
              r_coin5   <= req_ntd5;
              r_coin1   <= req_ntd1;
              r_itemReq <= req_item;
            end else begin
              r_rspValid  <= 1'b1;
              r_rspStatus <= CUST_REJECTED;
              r_rspItem   <= ITEM_NONE;
              r_rspPaid   <= w_paidValue[7:0];
              r_rspChange <= 10'd0;
            end
          end
        end
        CS_ISSUE, CS_WAIT: begin
          r_count <= w_countNext;
          if (w_stateNext != CS_ISSUE) begin
            r_coin50  <= 2'd0;
            r_coin10  <= 2'd0;
            r_coin5   <= 2'd0;
            r_coin1   <= 2'd0;
            r_itemReq <= ITEM_NONE;
          end
          if (w_capture) begin
            r_capItem <= vend_item;
            r_cap50   <= vend_out50;
            r_cap10   <= vend_out10;
            r_cap5    <= vend_out5;
            r_cap1    <= vend_out1;
          end
          if (w_timeout) begin
            r_rspValid  <= 1'b1;
            r_rspStatus <= CUST_TIMEOUT;
            r_rspItem   <= ITEM_NONE;
            r_rspPaid   <= r_paid[7:0];
            r_rspChange <= 10'd0;
          end
        end
        CS_CHECK: begin
          r_rspValid  <= 1'b1;
          r_rspItem   <= r_capItem;
          r_rspPaid   <= r_paid[7:0];
          r_rspChange <= w_change;
          if ((r_capItem == r_reqItem) && w_balanced)
            r_rspStatus <= CUST_PURCHASED;
          else if ((r_capItem == ITEM_NONE) && w_balanced)
            r_rspStatus <= CUST_REFUNDED;
          else
            r_rspStatus <= CUST_MISMATCH;
        end
        CS_RESP: begin
          if (rsp_ready) r_rspValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_customer.sv
// Self-checking bench for vending_customer. The vending machine is scripted
// directly from the stimulus tasks; expected responses go into a scoreboard
// queue when a request is issued and are compared when the DUT hands a
// response over.
module tb_vending_customer;
  import vending_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_item;
  logic [1:0] req_ntd50, req_ntd10, req_ntd5, req_ntd1;
  logic [1:0] vend_service;
  logic [1:0] vend_item;
  logic [2:0] vend_out50, vend_out10, vend_out5, vend_out1;
  logic [1:0] coin_in50, coin_in10, coin_in5, coin_in1;
  logic [1:0] item_req;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_status;
  logic [1:0] rsp_item;
  logic [7:0] rsp_paid;
  logic [9:0] rsp_change;

  typedef struct {
    logic [2:0] status;
    logic [1:0] item;
    logic [7:0] paid;
    logic [9:0] change;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   nChecks = 0;
  int   nErrors = 0;

  vending_customer #(.TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_item     (req_item),
    .req_ntd50    (req_ntd50),
    .req_ntd10    (req_ntd10),
    .req_ntd5     (req_ntd5),
    .req_ntd1     (req_ntd1),
    .vend_service (vend_service),
    .vend_item    (vend_item),
    .vend_out50   (vend_out50),
    .vend_out10   (vend_out10),
    .vend_out5    (vend_out5),
    .vend_out1    (vend_out1),
    .coin_in50    (coin_in50),
    .coin_in10    (coin_in10),
    .coin_in5     (coin_in5),
    .coin_in1     (coin_in1),
    .item_req     (item_req),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_status   (rsp_status),
    .rsp_item     (rsp_item),
    .rsp_paid     (rsp_paid),
    .rsp_change   (rsp_change)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Scoreboard: each completed response handshake pops one expectation
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRsp", 32'(expQ.size()), 32'd1);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("rspStatus", rsp_status, monExp.status);
        checkOutput("rspItem",   rsp_item,   monExp.item);
        checkOutput("rspPaid",   rsp_paid,   monExp.paid);
        checkOutput("rspChange", rsp_change, monExp.change);
      end
    end
  end

  // Waits for IDLE, queues the expectation and presents one request; returns
  // #1 after the accepting edge.
  task automatic applyStimulus(input logic [1:0] item, input logic [1:0] n50,
                               input logic [1:0] n10, input logic [1:0] n5,
                               input logic [1:0] n1, input logic [2:0] eStatus,
                               input logic [1:0] eItem, input logic [7:0] ePaid,
                               input logic [9:0] eChange);
    exp_t e;
    for (int i = 0; i < 100 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reqReadyWait", req_ready, 1);
    e.status = eStatus;
    e.item   = eItem;
    e.paid   = ePaid;
    e.change = eChange;
    expQ.push_back(e);
    req_item  = item;
    req_ntd50 = n50;
    req_ntd10 = n10;
    req_ntd5  = n5;
    req_ntd1  = n1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("reqReadyLow", req_ready, 0);
  endtask

  // Plays the machine: checks the driven request, goes BUSY, then reports OFF
  // with the given item and change for exactly one cycle.
  task automatic runMachine(input logic [1:0] eItemReq, input logic [7:0] eCoins,
                            input logic [1:0] mItem, input logic [2:0] m50,
                            input logic [2:0] m10, input logic [2:0] m5,
                            input logic [2:0] m1, input int busyCycles);
    checkOutput("coinInDriven", {coin_in50, coin_in10, coin_in5, coin_in1}, eCoins);
    checkOutput("itemReqDriven", item_req, eItemReq);
    vend_service = SERVICE_BUSY;
    for (int i = 0; i < busyCycles; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("coinInWait", {coin_in50, coin_in10, coin_in5, coin_in1}, 0);
    checkOutput("itemReqWait", item_req, ITEM_NONE);
    vend_service = SERVICE_OFF;
    vend_item    = mItem;
    vend_out50   = m50;
    vend_out10   = m10;
    vend_out5    = m5;
    vend_out1    = m1;
    @(posedge clk);
    #1;
    vend_service = SERVICE_ON;
    vend_item    = ITEM_NONE;
    vend_out50   = 3'd0;
    vend_out10   = 3'd0;
    vend_out5    = 3'd0;
    vend_out1    = 3'd0;
    checkOutput("rspNotYet", rsp_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("rspValidLatency", rsp_valid, 1);
  endtask

  task automatic waitRsp();
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("rspDrained", 32'(expQ.size()), 0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_item     = ITEM_NONE;
    req_ntd50    = 2'd0;
    req_ntd10    = 2'd0;
    req_ntd5     = 2'd0;
    req_ntd1     = 2'd0;
    vend_service = SERVICE_ON;
    vend_item    = ITEM_NONE;
    vend_out50   = 3'd0;
    vend_out10   = 3'd0;
    vend_out5    = 3'd0;
    vend_out1    = 3'd0;
    rsp_ready    = 1'b1;

    #12;
    checkOutput("rstReqReady", req_ready, 1);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstRspFields", {rsp_status, rsp_item, rsp_paid, rsp_change}, 0);
    checkOutput("rstCoinIn", {coin_in50, coin_in10, coin_in5, coin_in1, item_req}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Purchase with change: A for 10, 2 back
    applyStimulus(ITEM_A, 2'd0, 2'd1, 2'd0, 2'd0, CUST_PURCHASED, ITEM_A, 8'd10, 10'd2);
    runMachine(ITEM_A, 8'b00_01_00_00, ITEM_A, 3'd0, 3'd0, 3'd0, 3'd2, 2);
    waitRsp();

    // Refund on insufficient funds: C with 10
    applyStimulus(ITEM_C, 2'd0, 2'd1, 2'd0, 2'd0, CUST_REFUNDED, ITEM_NONE, 8'd10, 10'd10);
    runMachine(ITEM_C, 8'b00_01_00_00, ITEM_NONE, 3'd0, 3'd1, 3'd0, 3'd0, 1);
    waitRsp();

    // Wrong change: B for 50, only 30 back
    applyStimulus(ITEM_B, 2'd1, 2'd0, 2'd0, 2'd0, CUST_MISMATCH, ITEM_B, 8'd50, 10'd30);
    runMachine(ITEM_B, 8'b01_00_00_00, ITEM_B, 3'd0, 3'd3, 3'd0, 3'd0, 3);
    waitRsp();

    // Wrong item delivered
    applyStimulus(ITEM_A, 2'd0, 2'd1, 2'd0, 2'd0, CUST_MISMATCH, ITEM_B, 8'd10, 10'd2);
    runMachine(ITEM_A, 8'b00_01_00_00, ITEM_B, 3'd0, 3'd0, 3'd0, 3'd2, 1);
    waitRsp();

    // Largest payment (198) for C, 176 back
    applyStimulus(ITEM_C, 2'd3, 2'd3, 2'd3, 2'd3, CUST_PURCHASED, ITEM_C, 8'd198, 10'd176);
    runMachine(ITEM_C, 8'b11_11_11_11, ITEM_C, 3'd3, 3'd2, 3'd1, 3'd1, 2);
    waitRsp();

    // Machine stuck in BUSY: response after 64 cycles in ISSUE+WAIT
    applyStimulus(ITEM_A, 2'd0, 2'd0, 2'd2, 2'd0, CUST_TIMEOUT, ITEM_NONE, 8'd10, 10'd0);
    vend_service = SERVICE_BUSY;
    for (int i = 0; i < 63; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("toNotEarly", rsp_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("toRspValid", rsp_valid, 1);
    checkOutput("toCoinIn", {coin_in50, coin_in10, coin_in5, coin_in1, item_req}, 0);
    vend_service = SERVICE_ON;
    waitRsp();

    // Reset while waiting on the machine, then a clean purchase
    applyStimulus(ITEM_A, 2'd0, 2'd0, 2'd2, 2'd0, CUST_PURCHASED, ITEM_A, 8'd10, 10'd2);
    vend_service = SERVICE_BUSY;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midRstReady", req_ready, 1);
    checkOutput("midRstRspValid", rsp_valid, 0);
    checkOutput("midRstOutputs", {coin_in50, coin_in10, coin_in5, coin_in1, item_req,
                                  rsp_status, rsp_item, rsp_paid, rsp_change}, 0);
    expQ.delete();
    vend_service = SERVICE_ON;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(ITEM_B, 2'd0, 2'd1, 2'd1, 2'd0, CUST_PURCHASED, ITEM_B, 8'd15, 10'd0);
    runMachine(ITEM_B, 8'b00_01_01_00, ITEM_B, 3'd0, 3'd0, 3'd0, 3'd0, 2);
    waitRsp();

    // Rejected request under back-pressure
    rsp_ready = 1'b0;
    applyStimulus(ITEM_NONE, 2'd0, 2'd1, 2'd0, 2'd0, CUST_REJECTED, ITEM_NONE, 8'd10, 10'd0);
    checkOutput("rejRspValid", rsp_valid, 1);
    checkOutput("rejNoDrive", {coin_in50, coin_in10, coin_in5, coin_in1, item_req}, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bpValid", rsp_valid, 1);
      checkOutput("bpFields", {rsp_status, rsp_item, rsp_paid, rsp_change},
                  {CUST_REJECTED, ITEM_NONE, 8'd10, 10'd0});
      checkOutput("bpNoDrive", {coin_in50, coin_in10, coin_in5, coin_in1, item_req}, 0);
    end
    rsp_ready = 1'b1;
    waitRsp();
    @(posedge clk);
    #1;
    checkOutput("bpReleased", {rsp_valid, req_ready}, 2'b01);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/vending_customer.md
# vending_customer

Customer-side transactor for `vendingMachine`; it is the initiator on the coin/item interface that the machine answers.

- Accepts one purchase request: item type plus counts of each coin to insert.
- Drives the machine's `coinInNTD_*` / `itemTypeIn` inputs and waits for the machine to finish (`SERVICE_OFF`).
- Captures the returned item and change coins, checks them against the expected outcome, and reports a status.
- Sits beside `vendingMachine` in the vending testbench and system top; usable as a stimulus generator and as a scoreboard front end.

## Interface

Parameters:
- `TIMEOUT`, default 64: maximum cycles spent in ISSUE+WAIT before aborting.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  1  purchase request present.
- `req_ready`  out  1  block can accept a request; equals (state==IDLE).
- `req_item`  in  2  requested item (`ITEM_*` encoding).
- `req_ntd50`, `req_ntd10`, `req_ntd5`, `req_ntd1`  in  2 each  coins to insert.
- `vend_service`  in  2  machine `serviceTypeOut`.
- `vend_item`  in  2  machine `itemTypeOut`.
- `vend_out50`, `vend_out10`, `vend_out5`, `vend_out1`  in  3 each  machine `coinOutNTD_*`.
- `coin_in50`, `coin_in10`, `coin_in5`, `coin_in1`  out  2 each  to machine `coinInNTD_*`.
- `item_req`  out  2  to machine `itemTypeIn`.
- `rsp_valid`  out  1  result available; held until accepted.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_status`  out  3  0 PURCHASED, 1 REFUNDED, 2 MISMATCH, 3 TIMEOUT, 4 REJECTED.
- `rsp_item`  out  2  item captured from the machine.
- `rsp_paid`  out  8  value inserted.
- `rsp_change`  out  10  value of change returned.

## Operation

States: IDLE, ISSUE, WAIT, CHECK, RESP.

- **IDLE**
  - `coin_in*`=0 and `item_req`=ITEM_NONE.
  - On `req_valid && req_ready`, latch the request and compute `paid = 50a+10b+5c+d` (8-bit; max 198).
  - If `req_item`==ITEM_NONE: status REJECTED, go to RESP.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Drive the latched coins and item continuously.
  - When `vend_service`==BUSY, go to WAIT.
  - The machine samples the request on any edge where it is in ON.
- **WAIT**
  - Drive `coin_in*`=0 and `item_req`=ITEM_NONE.
  - When `vend_service`==OFF, capture `vend_item` and `vend_out*` in that same cycle, then go to CHECK.
  - Capture timing is mandatory: the machine clears its outputs on the next edge.
- **CHECK** (one cycle)
  - `change = 50*o50 + 10*o10 + 5*o5 + o1`, computed in 10 bits (max 462, so no wrap).
  - Cost: A=8, B=15, C=22.
  - PURCHASED if captured item == requested item and `change == paid - cost`.
  - REFUNDED if captured item == NONE and `change == paid`.
  - MISMATCH otherwise, including a different non-NONE item.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1, all `rsp_*` fields stable.
  - Return to IDLE on the edge where `rsp_ready`=1.
- **Timeout**
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT, go to RESP with status TIMEOUT.
  - `rsp_item`=NONE and `rsp_change`=0; vend outputs return to idle.
  - Counter width is `$clog2(TIMEOUT+1)`.
- **Simultaneous events**: timeout and the OFF capture in the same cycle resolve as capture (CHECK wins).
- **Reset**: asserting `reset` in any state forces IDLE asynchronously and drops in-flight data; no response is produced for the aborted request.

## Timing

- **Reset values**:
  - `req_ready`=1, `rsp_valid`=0, `rsp_status`=0, `rsp_item`=0, `rsp_paid`=0, `rsp_change`=0.
  - `coin_in*`=0, `item_req`=ITEM_NONE.
- **Request to machine**: accept at edge N; `coin_in`/`item_req` valid from cycle N+1.
- **End of transaction**: OFF seen in cycle M gives CHECK in M+1 and `rsp_valid` in M+2.
- **Rejected request**: `rsp_valid` one cycle after acceptance.
- **Back-pressure**: `req_ready` is low from acceptance until the RESP handshake completes; one transaction is outstanding at a time.
- **Registered outputs**: all outputs are registered except `req_ready`, which decodes state.

## Structure

- **Shared package `vending_pkg`**:
  - `SERVICE_*`, `NTD_*`, `ITEM_*` encodings.
  - Coin values and item costs.
  - Status enum `cust_status_t`.
  - Customer FSM state typedef.
- **Sub-module `vending_value_calc`**:
  - Combinational coin-count-to-value (10-bit) and item-to-cost lookup.
  - Instantiated twice: paid and change.

## Test plan

- **Purchase with change**: item A, coins 0/1/0/0 (paid 10); machine returns item A, `out1`=2 → PURCHASED, `rsp_paid`=10, `rsp_change`=2.
- **Refund on insufficient funds**: item C, coins 0/1/0/0; machine returns item NONE, `out10`=1 → REFUNDED, `rsp_change`=10.
- **Wrong change**: item B, coins 1/0/0/0 (paid 50); machine returns item B, `out10`=3 (30) → MISMATCH, `rsp_change`=30.
- **Machine stuck**: machine held in BUSY with TIMEOUT=64 → TIMEOUT after 64 cycles in ISSUE+WAIT, `coin_in*`=0 and `item_req`=NONE, `rsp_change`=0.
- **Reset mid-transaction**: `reset` pulsed in WAIT → all outputs at reset values asynchronously, `req_ready`=1; a new request after reset completes normally.
- **Rejected request and back-pressure**: `req_item`=NONE → REJECTED one cycle later, machine inputs never driven; with `rsp_ready` held 0 for 5 cycles, `rsp_*` remain stable.
